// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// FSM state encoding, funct3 op encodings and operand-signedness helpers.
package alu_muldiv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // Divide/remainder ops all have funct3[2] set.
    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    // rs2 is treated as two's complement for MULH, DIV and REM (not MULHSU).
    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One-bit iteration step shared by multiply and divide.
// Multiply: right-shifting shift-add on the {acc, lo} product pair, lo holds the multiplier.
// Divide:   left-shifting restoring shift-subtract, acc = partial remainder, lo = dividend/quotient.
module alu_muldiv_seq_step #(
    parameter int XLEN = 32
) (
    input  logic            i_div,
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_mcand,
    output logic [XLEN-1:0] o_acc,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;

    // Compute both candidate updates; the mode picks one. Bit XLEN of w_diff is the borrow.
    always_comb begin
        w_sum    = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_mcand} : {(XLEN+1){1'b0}});
        w_rem_sh = {i_acc, i_lo[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, i_mcand};
        o_acc    = w_sum[XLEN:1];
        o_lo     = {w_sum[0], i_lo[XLEN-1:1]};
        if (i_div) begin
            if (!w_diff[XLEN]) begin
                o_acc = w_diff[XLEN-1:0];
                o_lo  = {i_lo[XLEN-2:0], 1'b1};
            end else begin
                o_acc = w_rem_sh[XLEN-1:0];
                o_lo  = {i_lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshake.
// Operands are reduced to magnitudes on accept, iterated one bit per cycle,
// then sign-corrected and selected in FIXUP. Division corner cases
// (divide by zero, MIN_INT / -1) can short-circuit straight to FIXUP.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_result;

    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_mcand;
    logic              r_qneg;
    logic              r_rneg;
    logic              r_early;
    logic [XLEN-1:0]   r_early_val;

    logic              w_accept;
    logic              w_step_en;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_early;
    logic [XLEN-1:0]   w_early_val;
    logic [XLEN-1:0]   w_step_acc;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_result;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign result    = r_result;
    assign w_accept  = in_valid && (r_state == ST_IDLE) && !flush;
    assign w_step_en = (r_state == ST_CALC) && (r_count != '0);

    alu_muldiv_seq_step #(.XLEN(XLEN)) u_step (
        .i_div   (op_is_div(r_op)),
        .i_acc   (r_acc),
        .i_lo    (r_lo),
        .i_mcand (r_mcand),
        .o_acc   (w_step_acc),
        .o_lo    (w_step_lo)
    );

    // Operand conditioning at accept: magnitudes, corner-case detection and short-circuit value.
    always_comb begin
        w_a_neg     = op_a_signed(op) & a[XLEN-1];
        w_b_neg     = op_b_signed(op) & b[XLEN-1];
        w_a_abs     = w_a_neg ? -a : a;
        w_b_abs     = w_b_neg ? -b : b;
        w_b_zero    = (b == '0);
        w_ovf       = ((op == MD_DIV) || (op == MD_REM)) && (a == MIN_INT) && (b == '1);
        w_early     = EARLY_OUT && op_is_div(op) && (w_b_zero || w_ovf);
        w_early_val = '0;
        if (w_b_zero) begin
            w_early_val = ((op == MD_REM) || (op == MD_REMU)) ? a : '1;
        end else if (op == MD_DIV) begin
            w_early_val = MIN_INT;
        end
    end

    // Sign correction and result selection once iteration has finished.
    always_comb begin
        w_prod       = {r_acc, r_lo};
        w_prod_fix   = r_qneg ? -w_prod : w_prod;
        w_quot       = r_qneg ? -r_lo : r_lo;
        w_rem        = r_rneg ? -r_acc : r_acc;
        w_fix_result = w_prod_fix[XLEN-1:0];
        case (r_op)
            MD_MULH, MD_MULHSU, MD_MULHU: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_fix_result = w_quot;
            MD_REM, MD_REMU:              w_fix_result = w_rem;
            default:                      w_fix_result = w_prod_fix[XLEN-1:0];
        endcase
        if (r_early) begin
            w_fix_result = r_early_val;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; CALC holds one extra cycle at count==0 before FIXUP, flush overrides all.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_nxt = w_early ? ST_FIXUP : ST_CALC;
            ST_CALC:  if (r_count == '0) w_state_nxt = ST_FIXUP;
            ST_FIXUP: w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Iteration counter and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_result <= '0;
        end else begin
            if (flush) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= CW'(XLEN);
            end else if (w_step_en) begin
                r_count <= r_count - 1'b1;
            end
            if ((r_state == ST_FIXUP) && !flush) begin
                r_result <= w_fix_result;
            end
        end
    end

    // Datapath registers: loaded on accept, advanced one bit per CALC cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op        <= op;
            r_acc       <= '0;
            r_lo        <= w_a_abs;
            r_mcand     <= w_b_abs;
            r_qneg      <= (w_a_neg ^ w_b_neg) & ~(op_is_div(op) & w_b_zero);
            r_rneg      <= w_a_neg;
            r_early     <= w_early;
            r_early_val <= w_early_val;
        end else if (w_step_en) begin
            r_acc <= w_step_acc;
            r_lo  <= w_step_lo;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq (XLEN=32, EARLY_OUT=1): directed RV32M cases,
// backpressure, flush, asynchronous reset and randomized operations
// against a plain-arithmetic reference model.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference result straight from the RISC-V M-extension definitions.
    function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * $signed(uy); return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 32'd0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    // Cycles from accept edge to out_valid: short-circuit corner cases take 1, everything else 34.
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && y == 32'd0) return 1;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Issue one op, measure latency, optionally stall the consumer, then complete the handshake.
    task automatic run_op(input string tag, input logic [2:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, input int hold);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        bit          rdy_seen;
        bit          unstable;
        logic [31:0] held;
        exp_res = ref_calc(t_op, t_a, t_b);
        exp_lat = ref_lat(t_op, t_a, t_b);
        wait_ready(tag);
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        rdy_seen = in_ready;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (in_ready) rdy_seen = 1'b1;
        end while (!out_valid && lat < 100);
        chk({tag, "_inready_low"}, {31'd0, rdy_seen}, 32'd0);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, result, exp_res);
        if (hold > 0) begin
            held = result;
            unstable = 1'b0;
            in_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
            end
            chk({tag, "_hold_stable"}, {31'd0, unstable}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_post_outvalid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_post_inready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        bit          seen_valid;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inready", {31'd0, in_ready}, 32'd1);
        chk("reset_outvalid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases
        run_op("mul_7x6",      3'd0, 32'd7,          32'd6,          0);
        run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000,  0);
        run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
        run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,          0);
        run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,          0);
        run_op("divu_max_16",  3'd5, 32'hFFFF_FFFF,  32'd16,         0);
        run_op("remu_max_16",  3'd7, 32'hFFFF_FFFF,  32'd16,         0);
        run_op("div_by_zero",  3'd4, 32'd1234,       32'd0,          0);
        run_op("rem_5_by_0",   3'd6, 32'd5,          32'd0,          0);
        run_op("divu_by_zero", 3'd5, 32'd77,         32'd0,          0);
        run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  0);
        run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  0);

        // Backpressure: consumer stalls 10 cycles, then a fresh op is accepted
        run_op("bp_mul",       3'd0, 32'h1234_5678,  32'h0000_0100,  10);
        run_op("bp_next",      3'd4, 32'd100,        32'hFFFF_FFF9,  0);

        // Flush during CALC
        wait_ready("flush");
        @(negedge clk);
        op = 3'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_inready", {31'd0, in_ready}, 32'd1);
        seen_valid = out_valid;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("flush_no_outvalid", {31'd0, seen_valid}, 32'd0);
        run_op("after_flush",  3'd1, 32'hFFFF_FFFE,  32'd3,          0);

        // Asynchronous reset mid-CALC
        wait_ready("rst");
        @(negedge clk);
        op = 3'd5; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_inready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_result", result, 32'd0);
        seen_valid = out_valid;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("rst_no_outvalid", {31'd0, seen_valid}, 32'd0);
        run_op("after_rst",    3'd7, 32'd1000,       32'd7,          0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = pick_operand();
            r_b  = pick_operand();
            run_op($sformatf("rand%0d_op%0d_%h_%h", i, r_op, r_a, r_b), r_op, r_a, r_b, (i % 9 == 0) ? 3 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
